// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: forwarding selects, load-use bubbles,
// wrong-path squash and multi-cycle data-memory hold for a 5-stage RISC-V core.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_LAT        = 2,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      regWriteM_i,
    input  logic                      regWriteW_i,
    input  logic                      resultSrcE_i,
    input  logic                      memAccessM_i,
    input  logic                      pcSrcE_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam logic                 MULTI_CYCLE = (MEM_LAT > 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD    = (MEM_LAT > 2) ? CNT_WIDTH'(MEM_LAT - 2) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 mem_stall;
    logic                 load_use;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;

    // The IDLE cycle that sees the access already stalls, so MEM_WAIT covers
    // the remaining MEM_LAT-1 cycles and RELEASE lets M advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memAccessM_i && MULTI_CYCLE) begin
                        state_q <= MEM_WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        mem_stall = ((state_q == IDLE) && memAccessM_i && MULTI_CYCLE) || (state_q == MEM_WAIT);
        load_use  = resultSrcE_i && (rdE_i != '0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
        fwd_a     = fwd_sel(rs1E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);
        fwd_b     = fwd_sel(rs2E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);
    end

    // Priority: memory hold, then taken-branch squash, then load-use bubble.
    // Everything is gated by rst_n so outputs drop the moment reset asserts.
    always_comb begin
        stallF_o    = 1'b0;
        stallD_o    = 1'b0;
        stallE_o    = 1'b0;
        stallM_o    = 1'b0;
        flushD_o    = 1'b0;
        flushE_o    = 1'b0;
        forwardAE_o = 2'b00;
        forwardBE_o = 2'b00;
        if (rst_n) begin
            forwardAE_o = fwd_a;
            forwardBE_o = fwd_b;
            if (mem_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
            end else if (pcSrcE_i) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (load_use) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl at MEM_LAT 4, 2 and 1 sharing one stimulus,
// checked each cycle against a stall-countdown model plus literal expectations.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regWriteM, regWriteW, resultSrcE, memAccessM, pcSrcE;

    // Control bundles: {stallF, stallD, stallE, stallM, flushD, flushE}
    wire [5:0] ctl4, ctl2, ctl1;
    wire [1:0] fa4, fb4, fa2, fb2, fa1, fb1;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_LAT(4), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .regWriteM_i(regWriteM), .regWriteW_i(regWriteW),
        .resultSrcE_i(resultSrcE), .memAccessM_i(memAccessM), .pcSrcE_i(pcSrcE),
        .stallF_o(ctl4[5]), .stallD_o(ctl4[4]), .stallE_o(ctl4[3]), .stallM_o(ctl4[2]),
        .flushD_o(ctl4[1]), .flushE_o(ctl4[0]),
        .forwardAE_o(fa4), .forwardBE_o(fb4)
    );

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_LAT(2), .CNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .regWriteM_i(regWriteM), .regWriteW_i(regWriteW),
        .resultSrcE_i(resultSrcE), .memAccessM_i(memAccessM), .pcSrcE_i(pcSrcE),
        .stallF_o(ctl2[5]), .stallD_o(ctl2[4]), .stallE_o(ctl2[3]), .stallM_o(ctl2[2]),
        .flushD_o(ctl2[1]), .flushE_o(ctl2[0]),
        .forwardAE_o(fa2), .forwardBE_o(fb2)
    );

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_LAT(1), .CNT_WIDTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .regWriteM_i(regWriteM), .regWriteW_i(regWriteW),
        .resultSrcE_i(resultSrcE), .memAccessM_i(memAccessM), .pcSrcE_i(pcSrcE),
        .stallF_o(ctl1[5]), .stallD_o(ctl1[4]), .stallE_o(ctl1[3]), .stallM_o(ctl1[2]),
        .flushD_o(ctl1[1]), .flushE_o(ctl1[0]),
        .forwardAE_o(fa1), .forwardBE_o(fb1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining stall cycles after the triggering one, and a flag for
    // the one un-stalled cycle in which the access leaves M.
    int lat[3] = '{4, 2, 1};
    int rem[3];
    bit rel[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                rem[k] <= 0;
                rel[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] > 0) begin
                    rem[k] <= rem[k] - 1;
                    rel[k] <= (rem[k] == 1);
                end else if (rel[k]) begin
                    rel[k] <= 1'b0;
                end else if (memAccessM && lat[k] > 1) begin
                    rem[k] <= lat[k] - 1;
                end
            end
        end
    end

    function automatic logic [5:0] exp_ctl(input int k);
        logic ms;
        logic lu;
        if (!rst_n) return 6'b000000;
        ms = (rem[k] > 0) || (!rel[k] && memAccessM && lat[k] > 1);
        if (ms) return 6'b111100;
        if (pcSrcE) return 6'b000011;
        lu = resultSrcE && (rdE != 0) && ((rdE == rs1D) || (rdE == rs2D));
        if (lu) return 6'b110001;
        return 6'b000000;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of all three instances against the model
    always @(negedge clk) begin
        check("ctl_L4", {2'b00, ctl4}, {2'b00, exp_ctl(0)});
        check("ctl_L2", {2'b00, ctl2}, {2'b00, exp_ctl(1)});
        check("ctl_L1", {2'b00, ctl1}, {2'b00, exp_ctl(2)});
        check("fwdA",   {2'b00, fa4, fa2, fa1}, {2'b00, {3{exp_fwd(rs1E)}}});
        check("fwdB",   {2'b00, fb4, fb2, fb1}, {2'b00, {3{exp_fwd(rs2E)}}});
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regWriteM, regWriteW, resultSrcE, memAccessM, pcSrcE} = '0;
    endtask

    logic [5:0] exp_q[$];

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        // Forwarding and memory requests present during reset must not leak out
        rs1E = 5'd5; rdM = 5'd5; regWriteM = 1'b1; memAccessM = 1'b1; pcSrcE = 1'b1;
        @(negedge clk);
        check("reset_ctl", {2'b00, ctl4}, 8'h00);
        check("reset_fwd", {4'h0, fa4, fb4}, 8'h00);
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;

        // Forward priority
        next_cycle();
        rs1E = 5'd5; rdM = 5'd5; regWriteM = 1'b1; rdW = 5'd5; regWriteW = 1'b1;
        @(negedge clk);
        check("fwd_m_prio", {6'd0, fa4}, 8'b10);
        next_cycle();
        regWriteM = 1'b0;
        @(negedge clk);
        check("fwd_w", {6'd0, fa4}, 8'b01);
        next_cycle();
        regWriteM = 1'b1; rdM = 5'd0; rdW = 5'd0; rs1E = 5'd0;
        @(negedge clk);
        check("fwd_x0", {6'd0, fa4}, 8'b00);
        next_cycle();
        rs1E = 5'd9; rdM = 5'd9; rs2E = 5'd3; rdW = 5'd3;
        @(negedge clk);
        check("fwd_indep", {4'h0, fa4, fb4}, 8'b1001);

        // Load-use: one bubble, then the load has moved on
        next_cycle();
        clear_inputs();
        resultSrcE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        @(negedge clk);
        check("load_use", {2'b00, ctl4}, 8'b110001);
        next_cycle();
        resultSrcE = 1'b0;
        @(negedge clk);
        check("load_use_once", {2'b00, ctl4}, 8'h00);
        next_cycle();
        resultSrcE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        @(negedge clk);
        check("load_use_x0", {2'b00, ctl4}, 8'h00);

        // Branch, alone and against a load-use
        next_cycle();
        clear_inputs();
        pcSrcE = 1'b1;
        @(negedge clk);
        check("branch", {2'b00, ctl4}, 8'b000011);
        next_cycle();
        resultSrcE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
        @(negedge clk);
        check("branch_over_lu", {2'b00, ctl4}, 8'b000011);

        // Memory wait, MEM_LAT=4: T..T+3 stalled, T+4 release
        next_cycle();
        clear_inputs();
        next_cycle();
        memAccessM = 1'b1;
        exp_q = '{6'b111100, 6'b111100, 6'b111100, 6'b111100, 6'b000000};
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check("mem_wait_L4", {2'b00, ctl4}, {2'b00, exp_q.pop_front()});
            check("mem_wait_L1", {2'b00, ctl1}, 8'h00);
            next_cycle();
        end
        // T+5: back in IDLE, the still-present access triggers afresh
        @(negedge clk);
        check("mem_retrigger", {2'b00, ctl4}, 8'b111100);
        next_cycle();
        memAccessM = 1'b0;
        repeat (6) next_cycle();

        // Branch masked during the hold, flushes on the release cycle
        memAccessM = 1'b1;
        exp_q = '{6'b111100, 6'b111100, 6'b111100, 6'b111100, 6'b000011};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) pcSrcE = 1'b1;
            @(negedge clk);
            check("mask_branch", {2'b00, ctl4}, {2'b00, exp_q.pop_front()});
            next_cycle();
        end
        clear_inputs();
        repeat (6) next_cycle();

        // Asynchronous reset at T+1 of a stall
        memAccessM = 1'b1;
        next_cycle();
        rs1E = 5'd4; rdM = 5'd4; regWriteM = 1'b1;
        #2;
        check("pre_reset_stall", {2'b00, ctl4}, 8'b111100);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {2'b00, ctl4}, 8'h00);
        check("async_rst_fwd", {6'd0, fa4}, 8'h00);
        clear_inputs();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        next_cycle();
        memAccessM = 1'b1;
        exp_q = '{6'b111100, 6'b111100, 6'b111100, 6'b111100, 6'b000000};
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check("post_rst_L4", {2'b00, ctl4}, {2'b00, exp_q.pop_front()});
            next_cycle();
        end
        memAccessM = 1'b0;
        repeat (3) next_cycle();

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
